// File: rtl/multisymbol_normalizer_pkg.sv
// Shared types and derived-size helpers for the multi-symbol normalizer.
package multisymbol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of RUN cycles needed to walk all symbols.
  function automatic int numchunks(input int numsymbols, input int symbolspercycle);
    return numsymbols / symbolspercycle;
  endfunction

  // Width of the signed inter-symbol carry.
  function automatic int carrywidth(input int symbolwidth, input int logradix);
    return symbolwidth - logradix + 2;
  endfunction

endpackage

// File: rtl/multisymbol_normalizer_if.sv
// Input/output valid-ready bus of the multi-symbol normalizer.
interface multisymbol_normalizer_if
  import multisymbol_pkg::*;
#(
  parameter int NUMSYMBOLS  = 32,
  parameter int LOGRADIX    = 33,
  parameter int SYMBOLWIDTH = 34
) ();

  localparam int CARRYWIDTH = carrywidth(SYMBOLWIDTH, LOGRADIX);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [NUMSYMBOLS-1:0][SYMBOLWIDTH-1:0]  in_symbols;
  logic                                    in_negate;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [NUMSYMBOLS*LOGRADIX-1:0]          out_data;
  logic signed [CARRYWIDTH-1:0]            out_carry;

  // Producer of symbols / consumer of results.
  modport master (
    output in_valid, in_symbols, in_negate, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  // The normalizer itself.
  modport slave (
    input  in_valid, in_symbols, in_negate, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );

endinterface

// File: rtl/multisymbol_normalizer_symbol_chunk_adder.sv
// Combinational carry ripple across one chunk of redundant symbols.
module symbol_chunk_adder
  import multisymbol_pkg::*;
#(
  parameter int SYMBOLSPERCYCLE    = 4,
  parameter int LOGRADIX           = 33,
  parameter int SYMBOLWIDTH        = 34,
  parameter int SYMBOLS_ARE_SIGNED = 1
) (
  input  logic [SYMBOLSPERCYCLE-1:0][SYMBOLWIDTH-1:0]      symbols,
  input  logic                                             negate,
  input  logic signed [carrywidth(SYMBOLWIDTH, LOGRADIX)-1:0] carry_in,
  output logic [LOGRADIX*SYMBOLSPERCYCLE-1:0]              data,
  output logic signed [carrywidth(SYMBOLWIDTH, LOGRADIX)-1:0] carry_out
);

  localparam int CARRYWIDTH = carrywidth(SYMBOLWIDTH, LOGRADIX);
  localparam int EXTW       = SYMBOLWIDTH + 2;

  logic signed [EXTW-1:0]       ext;
  logic signed [EXTW-1:0]       sum;
  logic signed [CARRYWIDTH-1:0] c;

  // Resolve symbols low to high, feeding each carry into the next symbol.
  always_comb begin
    data = '0;
    ext  = '0;
    sum  = '0;
    c    = carry_in;
    for (int unsigned j = 0; j < SYMBOLSPERCYCLE; j++) begin
      if (SYMBOLS_ARE_SIGNED != 0) begin
        ext = EXTW'($signed(symbols[j]));
      end else begin
        ext = EXTW'(symbols[j]);
      end
      if (negate) begin
        ext = -ext;
      end
      sum = ext + EXTW'(c);
      data[j*LOGRADIX +: LOGRADIX] = sum[LOGRADIX-1:0];
      c = CARRYWIDTH'(sum >>> LOGRADIX);
    end
    carry_out = c;
  end

endmodule

// File: rtl/multisymbol_normalizer.sv
// Sequential redundant-to-binary converter: SYMBOLSPERCYCLE symbols per RUN cycle.
module multisymbol_normalizer
  import multisymbol_pkg::*;
#(
  parameter int NUMSYMBOLS         = 32,
  parameter int LOGRADIX           = 33,
  parameter int SYMBOLWIDTH        = 34,
  parameter int SYMBOLSPERCYCLE    = 4,
  parameter int SYMBOLS_ARE_SIGNED = 1
) (
  input logic                     clk,
  input logic                     rst,
  multisymbol_normalizer_if.slave bus
);

  localparam int NUMCHUNKS  = numchunks(NUMSYMBOLS, SYMBOLSPERCYCLE);
  localparam int CARRYWIDTH = carrywidth(SYMBOLWIDTH, LOGRADIX);
  localparam int CHUNKBITS  = LOGRADIX * SYMBOLSPERCYCLE;
  localparam int CNTW       = (NUMCHUNKS > 1) ? $clog2(NUMCHUNKS) : 1;

  state_t state_q, state_d;

  logic [NUMSYMBOLS-1:0][SYMBOLWIDTH-1:0]      sym_q;
  logic                                        neg_q;
  logic signed [CARRYWIDTH-1:0]                carry_q;
  logic [CNTW-1:0]                             cnt_q;
  logic [NUMSYMBOLS*LOGRADIX-1:0]              data_q;
  logic signed [CARRYWIDTH-1:0]                out_carry_q;

  logic [SYMBOLSPERCYCLE-1:0][SYMBOLWIDTH-1:0] chunk_syms;
  logic [CHUNKBITS-1:0]                        chunk_bits;
  logic signed [CARRYWIDTH-1:0]                chunk_carry;
  logic                                        last_chunk;
  logic                                        accept;
  logic                                        in_ready_c;
  logic                                        out_valid_c;

  assign chunk_syms = sym_q[int'(cnt_q)*SYMBOLSPERCYCLE +: SYMBOLSPERCYCLE];
  assign last_chunk = (int'(cnt_q) == NUMCHUNKS - 1);

  symbol_chunk_adder #(
    .SYMBOLSPERCYCLE    (SYMBOLSPERCYCLE),
    .LOGRADIX           (LOGRADIX),
    .SYMBOLWIDTH        (SYMBOLWIDTH),
    .SYMBOLS_ARE_SIGNED (SYMBOLS_ARE_SIGNED)
  ) u_chunk_adder (
    .symbols   (chunk_syms),
    .negate    (neg_q),
    .carry_in  (carry_q),
    .data      (chunk_bits),
    .carry_out (chunk_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture operands on accept, then write one result chunk per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q       <= '0;
      neg_q       <= 1'b0;
      carry_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      out_carry_q <= '0;
    end else begin
      if (accept) begin
        sym_q   <= bus.in_symbols;
        neg_q   <= bus.in_negate;
        carry_q <= '0;
        cnt_q   <= '0;
      end
      if (state_q == RUN) begin
        data_q[int'(cnt_q)*CHUNKBITS +: CHUNKBITS] <= chunk_bits;
        carry_q <= chunk_carry;
        if (last_chunk) begin
          cnt_q       <= '0;
          out_carry_q <= chunk_carry;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
  assign bus.out_carry = out_carry_q;

endmodule
